// File: rtl/wb_trace_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// wb_trace_checker : buffers CPU writeback commits, checks them against a golden ROM trace
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_trace_checker #(
  parameter int FIFO_DEPTH  = 8,
  parameter int IDX_W       = 16,
  parameter int STOP_ON_ERR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      wb_pc,
  input  logic             wb_rf_wen,
  input  logic [4:0]       wb_rf_addr,
  input  logic [31:0]      wb_rf_wdata,
  output logic             gold_rd,
  output logic [IDX_W-1:0] gold_idx,
  input  logic [31:0]      gold_pc,
  input  logic [4:0]       gold_rf_addr,
  input  logic [31:0]      gold_rf_wdata,
  input  logic             gold_end,
  output logic             pass,
  output logic             fail,
  output logic [15:0]      err_count,
  output logic [IDX_W-1:0] chk_count,
  output logic [31:0]      first_err_pc
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam int         ENT_W   = 69;
  localparam logic [AW:0] C_DEPTH = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     chk_q, chk_d;
  logic [15:0]          err_q, err_d;
  logic [31:0]          first_q, first_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;

  logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          cnt_q;

  logic [31:0]          hold_pc_q;
  logic [4:0]           hold_addr_q;
  logic [31:0]          hold_data_q;

  logic                 w_cap, w_full, w_empty, w_pop, w_push, w_ovf, w_mism, w_wrap;
  logic [ENT_W-1:0]     w_head;

  always_comb begin
    w_cap   = wb_rf_wen && (wb_rf_addr != 5'd0);
    w_full  = (cnt_q == C_DEPTH);
    w_empty = (cnt_q == '0);
    w_pop   = (state_q == S_READY) && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    w_push  = w_cap && (state_q != S_DONE) && (!w_full || w_pop);
    w_ovf   = w_cap && (state_q != S_DONE) && w_full && !w_pop;
    w_head  = mem_q[rd_ptr_q];
    w_mism  = w_pop && (w_head != {hold_pc_q, hold_addr_q, hold_data_q});
    w_wrap  = w_pop && (idx_q == '1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (gold_end) begin
          state_d = S_DONE;
          // Leftover or simultaneous commits are beyond the end of the trace
          if ((err_q == 16'd0) && w_empty && !w_push) pass_d = 1'b1;
          else                                         fail_d = 1'b1;
        end else begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (w_pop) begin
          chk_d   = chk_q + 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = S_WAIT;
          if (w_mism) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0)    first_d = w_head[ENT_W-1 -: 32];
            if (STOP_ON_ERR != 0) begin
              fail_d  = 1'b1;
              state_d = S_DONE;
            end
          end
          if (w_wrap) begin
            fail_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        if (w_cap) begin
          fail_d = 1'b1;
          pass_d = 1'b0;
        end
      end
    endcase
    if (w_ovf) begin
      fail_d  = 1'b1;
      pass_d  = 1'b0;
      state_d = S_DONE;
    end
    gold_rd  = (state_d == S_WAIT);
    gold_idx = idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      idx_q   <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= {wb_pc, wb_rf_addr, wb_rf_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_pc_q   <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else if (state_q == S_WAIT) begin
      hold_pc_q   <= gold_pc;
      hold_addr_q <= gold_rf_addr;
      hold_data_q <= gold_rf_wdata;
    end
  end

  assign pass         = pass_q;
  assign fail         = fail_q;
  assign err_count    = err_q;
  assign chk_count    = chk_q;
  assign first_err_pc = first_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_wb_trace_checker : directed vector bench, three DUT instances with golden ROM models
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_trace_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] wb_pc = '0;
  logic        wb_rf_wen = 1'b0;
  logic [4:0]  wb_rf_addr = '0;
  logic [31:0] wb_rf_wdata = '0;
  int          trace_len = 2;

  int checks = 0;
  int errors = 0;

  // Instance A: STOP_ON_ERR=1, instance B: STOP_ON_ERR=0, instance C: 2-bit index
  logic        a_rd, a_end, a_pass, a_fail;
  logic [15:0] a_idx, a_err, a_chk;
  logic [31:0] a_gpc, a_gdata, a_first;
  logic [4:0]  a_gaddr;
  logic        b_rd, b_end, b_pass, b_fail;
  logic [15:0] b_idx, b_err, b_chk;
  logic [31:0] b_gpc, b_gdata, b_first;
  logic [4:0]  b_gaddr;
  logic        c_rd, c_end, c_pass, c_fail;
  logic [1:0]  c_idx, c_chk;
  logic [15:0] c_err;
  logic [31:0] c_gpc, c_gdata, c_first;
  logic [4:0]  c_gaddr;

  wb_trace_checker #(.FIFO_DEPTH(8), .IDX_W(16), .STOP_ON_ERR(1)) u_a (
    .clk(clk), .rst(rst), .wb_pc(wb_pc), .wb_rf_wen(wb_rf_wen), .wb_rf_addr(wb_rf_addr),
    .wb_rf_wdata(wb_rf_wdata), .gold_rd(a_rd), .gold_idx(a_idx), .gold_pc(a_gpc),
    .gold_rf_addr(a_gaddr), .gold_rf_wdata(a_gdata), .gold_end(a_end), .pass(a_pass),
    .fail(a_fail), .err_count(a_err), .chk_count(a_chk), .first_err_pc(a_first));

  wb_trace_checker #(.FIFO_DEPTH(8), .IDX_W(16), .STOP_ON_ERR(0)) u_b (
    .clk(clk), .rst(rst), .wb_pc(wb_pc), .wb_rf_wen(wb_rf_wen), .wb_rf_addr(wb_rf_addr),
    .wb_rf_wdata(wb_rf_wdata), .gold_rd(b_rd), .gold_idx(b_idx), .gold_pc(b_gpc),
    .gold_rf_addr(b_gaddr), .gold_rf_wdata(b_gdata), .gold_end(b_end), .pass(b_pass),
    .fail(b_fail), .err_count(b_err), .chk_count(b_chk), .first_err_pc(b_first));

  wb_trace_checker #(.FIFO_DEPTH(8), .IDX_W(2), .STOP_ON_ERR(1)) u_c (
    .clk(clk), .rst(rst), .wb_pc(wb_pc), .wb_rf_wen(wb_rf_wen), .wb_rf_addr(wb_rf_addr),
    .wb_rf_wdata(wb_rf_wdata), .gold_rd(c_rd), .gold_idx(c_idx), .gold_pc(c_gpc),
    .gold_rf_addr(c_gaddr), .gold_rf_wdata(c_gdata), .gold_end(c_end), .pass(c_pass),
    .fail(c_fail), .err_count(c_err), .chk_count(c_chk), .first_err_pc(c_first));

  // Golden record i: pc 0x00400000+4i, register 8+(i%23), value 5+2i; end at trace_len
  function automatic logic [69:0] rec(input int idx);
    logic [31:0] pc, data;
    logic [4:0]  addr;
    pc   = 32'h0040_0000 + 32'(idx * 4);
    addr = 5'((idx % 23) + 8);
    data = 32'(5 + 2 * idx);
    return {(idx >= trace_len), pc, addr, data};
  endfunction

  initial begin
    {a_end, a_gpc, a_gaddr, a_gdata} = '0;
    {b_end, b_gpc, b_gaddr, b_gdata} = '0;
    {c_end, c_gpc, c_gaddr, c_gdata} = '0;
  end

  always @(posedge clk) begin
    if (a_rd) {a_end, a_gpc, a_gaddr, a_gdata} <= rec(int'(a_idx));
    if (b_rd) {b_end, b_gpc, b_gaddr, b_gdata} <= rec(int'(b_idx));
    if (c_rd) {c_end, c_gpc, c_gaddr, c_gdata} <= rec(int'(c_idx));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wb_rf_wen = 1'b0;
    end
  endtask

  task automatic send(input int i, input bit bad);
    logic [69:0] r;
    r = rec(i);
    @(negedge clk);
    wb_rf_wen   = 1'b1;
    wb_pc       = r[68:37];
    wb_rf_addr  = r[36:32];
    wb_rf_wdata = bad ? r[31:0] + 32'd1 : r[31:0];
  endtask

  task automatic send_zero();
    @(negedge clk);
    wb_rf_wen   = 1'b1;
    wb_pc       = 32'hDEAD_0000;
    wb_rf_addr  = 5'd0;
    wb_rf_wdata = 32'h1234_5678;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wb_rf_wen = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  typedef struct {
    int          ncommit;
    int          tlen;
    int          gap;
    logic [31:0] bad;
    bit          zeros;
    bit          ap, af;
    int          ae, ac;
    logic [31:0] afp;
    bit          bp, bf;
    int          be, bc;
    logic [31:0] bfp;
  } vec_t;

  vec_t vt[6];

  initial begin
    // ncommit tlen gap bad zeros | A: pass fail err chk first | B: pass fail err chk first
    vt[0] = '{2, 2, 2, 32'h0, 1'b0, 1'b1, 1'b0, 0, 2, 32'h0,        1'b1, 1'b0, 0, 2, 32'h0};
    vt[1] = '{2, 2, 2, 32'h2, 1'b0, 1'b0, 1'b1, 1, 2, 32'h00400004, 1'b0, 1'b1, 1, 2, 32'h00400004};
    vt[2] = '{3, 3, 2, 32'h5, 1'b0, 1'b0, 1'b1, 1, 1, 32'h00400000, 1'b0, 1'b1, 2, 3, 32'h00400000};
    vt[3] = '{2, 2, 2, 32'h0, 1'b1, 1'b1, 1'b0, 0, 2, 32'h0,        1'b1, 1'b0, 0, 2, 32'h0};
    vt[4] = '{9, 9, 0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 9, 32'h0,        1'b1, 1'b0, 0, 9, 32'h0};
    vt[5] = '{20, 30, 0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 8, 32'h0,      1'b0, 1'b1, 0, 8, 32'h0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst pass",  {31'h0, a_pass}, 32'h0);
    check("rst fail",  {31'h0, a_fail}, 32'h0);
    check("rst err",   {16'h0, a_err},  32'h0);
    check("rst chk",   {16'h0, a_chk},  32'h0);
    check("rst first", a_first,         32'h0);
    check("rst idx",   {16'h0, a_idx},  32'h0);

    for (int k = 0; k < 6; k++) begin
      trace_len = vt[k].tlen;
      do_reset();
      for (int i = 0; i < vt[k].ncommit; i++) begin
        if (vt[k].zeros) begin
          send_zero();
          idle(vt[k].gap);
        end
        send(i, vt[k].bad[i]);
        idle(vt[k].gap);
      end
      idle(60);
      check($sformatf("v%0d a_pass", k),  {31'h0, a_pass}, {31'h0, vt[k].ap});
      check($sformatf("v%0d a_fail", k),  {31'h0, a_fail}, {31'h0, vt[k].af});
      check($sformatf("v%0d a_err", k),   {16'h0, a_err},  32'(vt[k].ae));
      check($sformatf("v%0d a_chk", k),   {16'h0, a_chk},  32'(vt[k].ac));
      check($sformatf("v%0d a_first", k), a_first,         vt[k].afp);
      check($sformatf("v%0d b_pass", k),  {31'h0, b_pass}, {31'h0, vt[k].bp});
      check($sformatf("v%0d b_fail", k),  {31'h0, b_fail}, {31'h0, vt[k].bf});
      check($sformatf("v%0d b_err", k),   {16'h0, b_err},  32'(vt[k].be));
      check($sformatf("v%0d b_chk", k),   {16'h0, b_chk},  32'(vt[k].bc));
      check($sformatf("v%0d b_first", k), b_first,         vt[k].bfp);
    end

    // Commit arriving after the end marker turns a pass into a fail
    trace_len = 2;
    do_reset();
    send(0, 1'b0); idle(2);
    send(1, 1'b0); idle(20);
    check("late pass before", {31'h0, a_pass}, 32'h1);
    send(2, 1'b0); idle(3);
    check("late pass after", {31'h0, a_pass}, 32'h0);
    check("late fail after", {31'h0, a_fail}, 32'h1);

    // Reset asserted while in WAIT
    trace_len = 30;
    do_reset();
    send(0, 1'b0);
    @(negedge clk);
    wb_rf_wen = 1'b0;
    @(negedge clk);
    check("wait chk", {16'h0, a_chk}, 32'h1);
    check("wait rd",  {31'h0, a_rd},  32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rstw idx",  {16'h0, a_idx},  32'h0);
    check("rstw chk",  {16'h0, a_chk},  32'h0);
    check("rstw rd",   {31'h0, a_rd},   32'h1);
    check("rstw pass", {31'h0, a_pass}, 32'h0);
    check("rstw fail", {31'h0, a_fail}, 32'h0);
    rst = 1'b0;

    // Index wrap on the 2-bit instance
    trace_len = 30;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(i, 1'b0);
      idle(2);
    end
    idle(10);
    check("wrap fail pre", {31'h0, c_fail}, 32'h0);
    check("wrap chk pre",  {30'h0, c_chk},  32'h3);
    send(3, 1'b0);
    idle(10);
    check("wrap fail", {31'h0, c_fail}, 32'h1);
    check("wrap pass", {31'h0, c_pass}, 32'h0);
    check("wrap a ok", {31'h0, a_fail}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
